note_sequencer: RTL and testbench

//  Parametrised record/playback note store for the music device. Captures {octave,note}

---
 rtl/note_sequencer_if.sv | 43 ++++
 rtl/note_sequencer.sv | 165 ++++++++++++++++
 tb/tb_note_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Purpose : bundles the record/playback signals of note_sequencer.
//   master : control side (keypad capture, transport controls, tempo)
//   slave  : the sequencer itself
// Signals : note_data/octave_data/rec_strobe (record), play_start/stop/clear/
//           loop_en/ticks_per_note (transport), note_out/octave_out/note_valid/
//           playing/count/full/overflow/done (status and playback)
interface note_sequencer_if #(
  parameter int NOTE_W = 4,
  parameter int OCT_W  = 2,
  parameter int ADDR_W = 4,
  parameter int TICK_W = 24
);
  logic [NOTE_W-1:0] note_data;
  logic [OCT_W-1:0]  octave_data;
  logic              rec_strobe;
  logic              play_start;
  logic              stop;
  logic              clear;
  logic              loop_en;
  logic [TICK_W-1:0] ticks_per_note;
  logic [NOTE_W-1:0] note_out;
  logic [OCT_W-1:0]  octave_out;
  logic              note_valid;
  logic              playing;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;
  logic              done;

  modport master (
    output note_data, octave_data, rec_strobe, play_start, stop, clear,
           loop_en, ticks_per_note,
    input  note_out, octave_out, note_valid, playing, count, full,
           overflow, done
  );

  modport slave (
    input  note_data, octave_data, rec_strobe, play_start, stop, clear,
           loop_en, ticks_per_note,
    output note_out, octave_out, note_valid, playing, count, full,
           overflow, done
  );
endinterface

// File: rtl/note_sequencer.sv
// Purpose : record/playback note store. Rising edges of rec_strobe append
//           {octave,note} entries to an internal RAM; play_start replays them,
//           each held for max(ticks_per_note,1) cycles, once or looped.
// Ports   : clk   - system clock, rising edge
//           reset - synchronous, active-low
//           bus   - note_sequencer_if.slave (record inputs, transport controls,
//                   playback outputs and status; all outputs registered)
module note_sequencer #(
  parameter int NOTE_W = 4,
  parameter int OCT_W  = 2,
  parameter int ADDR_W = 4,
  parameter int TICK_W = 24
) (
  input  logic            clk,
  input  logic            reset,
  note_sequencer_if.slave bus
);
  localparam int ENTRY_W = NOTE_W + OCT_W;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PLAY = 1'b1} state_t;

  state_t              state_r;
  logic [ENTRY_W-1:0]  mem_r [DEPTH];
  logic [ADDR_W:0]     count_r;
  logic                full_r;
  logic                strobe_prev_r;
  logic [ADDR_W-1:0]   play_idx_r;
  logic [TICK_W-1:0]   tick_r;
  logic [NOTE_W-1:0]   note_r;
  logic [OCT_W-1:0]    oct_r;
  logic                valid_r;
  logic                playing_r;
  logic                overflow_r;
  logic                done_r;

  logic                rise_s;
  logic                play_go_s;
  logic                rec_slot_s;
  logic                wr_en_s;
  logic                ovf_s;
  logic                last_s;
  logic [ADDR_W-1:0]   next_idx_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic [ENTRY_W-1:0]  rd_data_s;
  logic [TICK_W-1:0]   tick_load_s;

  assign bus.note_out   = note_r;
  assign bus.octave_out = oct_r;
  assign bus.note_valid = valid_r;
  assign bus.playing    = playing_r;
  assign bus.count      = count_r;
  assign bus.full       = full_r;
  assign bus.overflow   = overflow_r;
  assign bus.done       = done_r;

  // Decode record/play requests and the next playback address.
  always_comb begin
    rise_s    = bus.rec_strobe & ~strobe_prev_r;
    play_go_s = bus.play_start & (count_r != {(ADDR_W+1){1'b0}});
    // A record edge only counts in IDLE when no higher-priority request is taken.
    if (reset && (state_r == ST_IDLE) && !bus.stop && !bus.clear && !play_go_s) begin
      rec_slot_s = rise_s;
    end else begin
      rec_slot_s = 1'b0;
    end
    wr_en_s = rec_slot_s & ~full_r;
    ovf_s   = rec_slot_s & full_r;
    // Hold counter counts down to zero, so load N-1; a tempo of 0 behaves as 1.
    if (bus.ticks_per_note == {TICK_W{1'b0}}) begin
      tick_load_s = {TICK_W{1'b0}};
    end else begin
      tick_load_s = bus.ticks_per_note - TICK_W'(1'b1);
    end
    last_s = (({1'b0, play_idx_r} + (ADDR_W+1)'(1'b1)) == count_r);
    if (last_s) begin
      next_idx_s = {ADDR_W{1'b0}};
    end else begin
      next_idx_s = play_idx_r + ADDR_W'(1'b1);
    end
    // The first note after start comes from entry 0; later ones from the successor.
    if (valid_r) begin
      rd_addr_s = next_idx_s;
    end else begin
      rd_addr_s = {ADDR_W{1'b0}};
    end
    rd_data_s = mem_r[rd_addr_s];
  end

  // Note store write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[count_r[ADDR_W-1:0]] <= {bus.octave_data, bus.note_data};
    end
  end

  // Control FSM, store occupancy and registered playback outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      count_r       <= {(ADDR_W+1){1'b0}};
      full_r        <= 1'b0;
      strobe_prev_r <= 1'b0;
      play_idx_r    <= {ADDR_W{1'b0}};
      tick_r        <= {TICK_W{1'b0}};
      note_r        <= {NOTE_W{1'b0}};
      oct_r         <= {OCT_W{1'b0}};
      valid_r       <= 1'b0;
      playing_r     <= 1'b0;
      overflow_r    <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      // Edge detector tracks the strobe in every state.
      strobe_prev_r <= bus.rec_strobe;
      overflow_r    <= ovf_s;
      done_r        <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.stop) begin
            state_r <= ST_IDLE;
          end else if (bus.clear) begin
            count_r <= {(ADDR_W+1){1'b0}};
            full_r  <= 1'b0;
          end else if (play_go_s) begin
            state_r    <= ST_PLAY;
            playing_r  <= 1'b1;
            valid_r    <= 1'b0;
            play_idx_r <= {ADDR_W{1'b0}};
          end else if (wr_en_s) begin
            count_r <= count_r + (ADDR_W+1)'(1'b1);
            full_r  <= ((count_r + (ADDR_W+1)'(1'b1)) == FULL_CNT);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (bus.stop || (valid_r && (tick_r == {TICK_W{1'b0}}) && last_s && !bus.loop_en)) begin
            // Abort or natural end of a one-shot pass; only the latter reports done.
            state_r   <= ST_IDLE;
            playing_r <= 1'b0;
            valid_r   <= 1'b0;
            note_r    <= {NOTE_W{1'b0}};
            oct_r     <= {OCT_W{1'b0}};
            done_r    <= ~bus.stop;
          end else if (valid_r && (tick_r != {TICK_W{1'b0}})) begin
            tick_r <= tick_r - TICK_W'(1'b1);
          end else begin
            // Note boundary (or first note): present the next entry, reload tempo.
            note_r     <= rd_data_s[NOTE_W-1:0];
            oct_r      <= rd_data_s[ENTRY_W-1:NOTE_W];
            valid_r    <= 1'b1;
            play_idx_r <= rd_addr_s;
            tick_r     <= tick_load_s;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          playing_r <= 1'b0;
          valid_r   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
  logic clk;
  logic reset;

  note_sequencer_if #(.NOTE_W(4), .OCT_W(2), .ADDR_W(4), .TICK_W(24)) bus ();

  note_sequencer #(.NOTE_W(4), .OCT_W(2), .ADDR_W(4), .TICK_W(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ovf_cnt = 0;

  // Reference model: stored entries and expected playback stream.
  logic [5:0] model_mem [$];
  logic [5:0] exp_q [$];

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops expected notes whenever the DUT presents one.
  always @(negedge clk) begin
    if (bus.note_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_note actual=%0h expected=none at %0t",
                 {bus.octave_out, bus.note_out}, $time);
      end else begin
        chk("note", int'({bus.octave_out, bus.note_out}), int'(exp_q.pop_front()));
      end
    end else begin
      chk("idle_zero", int'({bus.octave_out, bus.note_out}), 0);
    end
    if (bus.done) done_cnt++;
    if (bus.overflow) ovf_cnt++;
  end

  function automatic void push_play(input int ticks, input int rounds);
    int n;
    n = (ticks == 0) ? 1 : ticks;
    for (int r = 0; r < rounds; r++)
      foreach (model_mem[i])
        for (int k = 0; k < n; k++) exp_q.push_back(model_mem[i]);
  endfunction

  task automatic rec(input logic [3:0] n, input logic [1:0] o);
    @(posedge clk); #1;
    bus.note_data = n; bus.octave_data = o; bus.rec_strobe = 1'b1;
    @(posedge clk); #1;
    bus.rec_strobe = 1'b0;
    @(posedge clk); #1;
    if (model_mem.size() < 16) model_mem.push_back({o, n});
  endtask

  task automatic rec_rand();
    rec(4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)));
  endtask

  task automatic do_clear();
    @(posedge clk); #1; bus.clear = 1'b1;
    @(posedge clk); #1; bus.clear = 1'b0;
    model_mem.delete();
  endtask

  task automatic start_play();
    @(posedge clk); #1; bus.play_start = 1'b1;
    @(posedge clk); #1; bus.play_start = 1'b0;
    @(negedge clk);
    chk("start_playing", int'(bus.playing), 1);
    chk("start_valid_low", int'(bus.note_valid), 0);
    @(negedge clk);
    chk("start_valid_high", int'(bus.note_valid), 1);
  endtask

  task automatic play_once(input int ticks);
    int pc;
    int d0;
    int n;
    n = (ticks == 0) ? 1 : ticks;
    bus.ticks_per_note = 24'(ticks);
    bus.loop_en = 1'b0;
    d0 = done_cnt;
    push_play(ticks, 1);
    start_play();
    pc = 2;
    for (int b = 0; b < 3000; b++) begin
      @(negedge clk);
      if (!bus.playing) break;
      pc++;
    end
    chk("play_cycles", pc, 1 + model_mem.size() * n);
    chk("done_pulse", int'(bus.done), 1);
    @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("count_after_play", int'(bus.count), model_mem.size());
  endtask

  initial begin
    int d0;
    int o0;
    bus.note_data = 4'd0; bus.octave_data = 2'd0; bus.rec_strobe = 1'b0;
    bus.play_start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
    bus.loop_en = 1'b0; bus.ticks_per_note = 24'd1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_playing", int'(bus.playing), 0);
    chk("rst_valid", int'(bus.note_valid), 0);
    @(posedge clk); #1; reset = 1'b1;

    // Three known entries, 4 cycles each, one-shot.
    rec(4'd1, 2'd0); rec(4'd5, 2'd1); rec(4'd11, 2'd3);
    chk("count3", int'(bus.count), 3);
    play_once(4);

    // Randomised record/playback rounds.
    for (int it = 0; it < 3; it++) begin
      do_clear();
      for (int k = 0; k < int'($urandom_range(6, 2)); k++) rec_rand();
      chk("count_rand", int'(bus.count), model_mem.size());
      play_once(int'($urandom_range(5, 1)));
    end

    // Fill to depth, then one more record is dropped with an overflow pulse.
    do_clear();
    for (int k = 0; k < 16; k++) rec_rand();
    chk("count_full", int'(bus.count), 16);
    chk("full_flag", int'(bus.full), 1);
    o0 = ovf_cnt;
    rec_rand();
    chk("count_after_ovf", int'(bus.count), 16);
    chk("overflow_once", ovf_cnt - o0, 1);
    play_once(1);

    // Looped two-entry playback, then stop.
    do_clear();
    rec_rand(); rec_rand();
    bus.ticks_per_note = 24'd2; bus.loop_en = 1'b1;
    d0 = done_cnt;
    push_play(2, 3);
    start_play();
    for (int b = 0; b < 200; b++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    chk("loop_drained", exp_q.size(), 0);
    bus.stop = 1'b1;
    @(posedge clk); #1; bus.stop = 1'b0; bus.loop_en = 1'b0;
    @(negedge clk);
    chk("stop_valid", int'(bus.note_valid), 0);
    chk("stop_playing", int'(bus.playing), 0);
    @(negedge clk);
    chk("stop_no_done", done_cnt - d0, 0);

    // Held strobe records once; tempo 0 plays one cycle per note.
    do_clear();
    @(posedge clk); #1;
    bus.note_data = 4'd9; bus.octave_data = 2'd2; bus.rec_strobe = 1'b1;
    repeat (10) @(posedge clk);
    #1; bus.rec_strobe = 1'b0;
    model_mem.push_back({2'd2, 4'd9});
    @(posedge clk); #1;
    chk("held_strobe_count", int'(bus.count), 1);
    rec_rand(); rec_rand();
    play_once(0);

    // play_start with an empty store is ignored; clear empties the store.
    do_clear();
    chk("clear_count", int'(bus.count), 0);
    @(posedge clk); #1; bus.play_start = 1'b1;
    @(posedge clk); #1; bus.play_start = 1'b0;
    @(negedge clk);
    chk("empty_no_play", int'(bus.playing), 0);
    @(negedge clk);
    chk("empty_no_play2", int'(bus.playing), 0);
    rec_rand(); rec_rand();
    chk("count2", int'(bus.count), 2);
    do_clear();
    chk("clear_count2", int'(bus.count), 0);
    chk("clear_full", int'(bus.full), 0);

    // Reset mid-playback aborts; the block then works again.
    rec_rand(); rec_rand();
    bus.ticks_per_note = 24'd3; bus.loop_en = 1'b1;
    d0 = done_cnt;
    push_play(3, 10);
    start_play();
    repeat (7) @(negedge clk);
    #1; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; bus.loop_en = 1'b0;
    exp_q.delete(); model_mem.delete();
    @(negedge clk);
    chk("rst_play_valid", int'(bus.note_valid), 0);
    chk("rst_play_playing", int'(bus.playing), 0);
    chk("rst_play_count", int'(bus.count), 0);
    chk("rst_play_no_done", done_cnt - d0, 0);
    rec(4'd7, 2'd1);
    play_once(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
